// File: rtl/mem_lsu_if.sv
// Request/response and byte-lane RAM bus of the load/store unit.
// The slave modport is the LSU's view; the master modport is the CPU/RAM side.
interface mem_lsu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [1:0]              req_size;
    logic                    req_unsigned;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;

    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;

    logic [DATA_WIDTH/8-1:0] ram_wen;
    logic [ADDR_WIDTH-1:0]   ram_w_addr;
    logic [DATA_WIDTH-1:0]   ram_w_data;
    logic                    ram_ren;
    logic [ADDR_WIDTH-1:0]   ram_r_addr;
    logic [DATA_WIDTH-1:0]   ram_r_data;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  ram_r_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ram_wen, ram_w_addr, ram_w_data, ram_ren, ram_r_addr
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output ram_r_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ram_wen, ram_w_addr, ram_w_data, ram_ren, ram_r_addr
    );
endinterface

// File: rtl/mem_lsu.sv
// Load/store initiator for the 4-lane data RAM: one request at a time, lane masks,
// rotated store data, aligned/extended load data. MISALIGN_SPLIT_EN splits misaligned accesses.
module mem_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic     sys_clk,
    input  logic     sys_rst_n,
    mem_lsu_if.slave bus
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-3:0] WORD_ONE = 1;

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE1,
        S_ISSUE2,
        S_WAIT
    } state_t;

    state_t state, state_nxt;

    function automatic logic [LANES-1:0] size_mask(input logic [1:0] size);
        logic [LANES-1:0] m;
        case (size)
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = (lane[0] == 1'b0);
            2'd2:    ok = (lane == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Rotating (not shifting) keeps the spilled high bytes in the low lanes for a split second word.
    function automatic logic [DATA_WIDTH-1:0] rotl_lanes(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [1:0] lane);
        logic [DATA_WIDTH-1:0] r;
        case (lane)
            2'd0:    r = d;
            2'd1:    r = {d[23:0], d[31:24]};
            2'd2:    r = {d[15:0], d[31:16]};
            default: r = {d[7:0],  d[31:8]};
        endcase
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2*DATA_WIDTH-1:0] dw,
                                                          input logic [1:0] size,
                                                          input logic uns,
                                                          input logic [1:0] lane);
        logic [2*DATA_WIDTH-1:0] sh;
        logic signed [7:0]       byte_s;
        logic signed [15:0]      half_s;
        logic [DATA_WIDTH-1:0]   r;
        sh     = dw >> {lane, 3'b000};
        byte_s = sh[7:0];
        half_s = sh[15:0];
        case (size)
            2'd0:    r = uns ? {24'd0, sh[7:0]}  : 32'(byte_s);
            2'd1:    r = uns ? {16'd0, sh[15:0]} : 32'(half_s);
            default: r = sh[DATA_WIDTH-1:0];
        endcase
        return r;
    endfunction

    logic accept;
    logic rsvd_in, misal_in;

    assign accept   = bus.req_valid && (state == S_IDLE);
    assign rsvd_in  = (bus.req_size == 2'd3);
    assign misal_in = !rsvd_in && !is_aligned(bus.req_size, bus.req_addr[1:0]);

    // Stage p1: request registered at acceptance
    logic                  we_p1;
    logic [1:0]            size_p1;
    logic                  uns_p1;
    logic                  split_p1;
    logic                  err_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [DATA_WIDTH-1:0] wdata_p1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            we_p1    <= 1'b0;
            size_p1  <= 2'd0;
            uns_p1   <= 1'b0;
            split_p1 <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_p1    <= bus.req_we;
                size_p1  <= bus.req_size;
                uns_p1   <= bus.req_unsigned;
                split_p1 <= misal_in && SPLIT_EN;
                err_p1   <= rsvd_in || (misal_in && !SPLIT_EN);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (accept) begin
            addr_p1  <= bus.req_addr;
            wdata_p1 <= rotl_lanes(bus.req_wdata, bus.req_addr[1:0]);
        end
    end

    // Stage p2: first word of a split load, present on the RAM bus during ISSUE2
    logic [DATA_WIDTH-1:0] rlo_p2;

    always_ff @(posedge sys_clk) begin
        if (state == S_ISSUE2) begin
            rlo_p2 <= bus.ram_r_data;
        end
    end

    logic [1:0]            lane_p1;
    logic [2*LANES-1:0]    foot_p1;
    logic [ADDR_WIDTH-1:0] addr_lo_p1;
    logic [ADDR_WIDTH-1:0] addr_hi_p1;
    logic [2*DATA_WIDTH-1:0] rd_dw;

    assign lane_p1    = addr_p1[1:0];
    assign foot_p1    = (2*LANES)'(size_mask(size_p1)) << lane_p1;
    assign addr_lo_p1 = {addr_p1[ADDR_WIDTH-1:2], 2'b00};
    assign addr_hi_p1 = {addr_p1[ADDR_WIDTH-1:2] + WORD_ONE, 2'b00};
    assign rd_dw      = split_p1 ? {bus.ram_r_data, rlo_p2} : {{DATA_WIDTH{1'b0}}, bus.ram_r_data};

    logic                  req_ready_c;
    logic                  rsp_valid_c;
    logic [DATA_WIDTH-1:0] rsp_rdata_c;
    logic                  rsp_err_c;
    logic [LANES-1:0]      ram_wen_c;
    logic [ADDR_WIDTH-1:0] ram_w_addr_c;
    logic [DATA_WIDTH-1:0] ram_w_data_c;
    logic                  ram_ren_c;
    logic [ADDR_WIDTH-1:0] ram_r_addr_c;

    always_comb begin
        state_nxt    = state;
        req_ready_c  = 1'b0;
        rsp_valid_c  = 1'b0;
        rsp_rdata_c  = '0;
        rsp_err_c    = 1'b0;
        ram_wen_c    = '0;
        ram_w_addr_c = '0;
        ram_w_data_c = '0;
        ram_ren_c    = 1'b0;
        ram_r_addr_c = '0;
        case (state)
            S_IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) state_nxt = S_ISSUE1;
            end
            S_ISSUE1: begin
                if (err_p1) begin
                    rsp_valid_c = 1'b1;
                    rsp_err_c   = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    if (we_p1) begin
                        ram_wen_c    = foot_p1[LANES-1:0];
                        ram_w_addr_c = addr_lo_p1;
                        ram_w_data_c = wdata_p1;
                    end else begin
                        ram_ren_c    = 1'b1;
                        ram_r_addr_c = addr_lo_p1;
                    end
                    if (split_p1) begin
                        state_nxt = S_ISSUE2;
                    end else if (we_p1) begin
                        rsp_valid_c = 1'b1;
                        state_nxt   = S_IDLE;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_ISSUE2: begin
                if (we_p1) begin
                    ram_wen_c    = foot_p1[2*LANES-1:LANES];
                    ram_w_addr_c = addr_hi_p1;
                    ram_w_data_c = wdata_p1;
                    rsp_valid_c  = 1'b1;
                    state_nxt    = S_IDLE;
                end else begin
                    ram_ren_c    = 1'b1;
                    ram_r_addr_c = addr_hi_p1;
                    state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                rsp_valid_c = 1'b1;
                rsp_rdata_c = load_extend(rd_dw, size_p1, uns_p1, lane_p1);
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.rsp_valid  = rsp_valid_c;
    assign bus.rsp_rdata  = rsp_rdata_c;
    assign bus.rsp_err    = rsp_err_c;
    assign bus.ram_wen    = ram_wen_c;
    assign bus.ram_w_addr = ram_w_addr_c;
    assign bus.ram_w_data = ram_w_data_c;
    assign bus.ram_ren    = ram_ren_c;
    assign bus.ram_r_addr = ram_r_addr_c;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a small byte-lane RAM behind it.
// Expectations follow MISALIGN_SPLIT_EN when the bench is built with it.
module tb_mem_lsu;

    logic sys_clk;
    logic sys_rst_n;
    int   n_assert;
    int   n_fail;

    mem_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // RAM with one-cycle read latency
    logic [31:0] mem [0:1023];
    always @(posedge sys_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.ram_wen[i]) mem[bus.ram_w_addr[11:2]][8*i +: 8] <= bus.ram_w_data[8*i +: 8];
        end
        if (bus.ram_ren) bus.ram_r_data <= mem[bus.ram_r_addr[11:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge sys_clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge sys_clk);
        #1;
        bus.req_valid    = 1'b0;
    endtask

    task automatic mid_cycle;
        @(negedge sys_clk);
    endtask

    initial begin
        n_assert         = 0;
        n_fail           = 0;
        sys_rst_n        = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.ram_r_data   = '0;

        repeat (2) @(negedge sys_clk);
        chk("rst_ready",  32'(bus.req_ready), 32'd1);
        chk("rst_rvalid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata",  bus.rsp_rdata, 32'h0);
        chk("rst_err",    32'(bus.rsp_err), 32'd0);
        chk("rst_wen",    32'(bus.ram_wen), 32'd0);
        chk("rst_ren",    32'(bus.ram_ren), 32'd0);
        chk("rst_waddr",  bus.ram_w_addr, 32'h0);
        chk("rst_wdata",  bus.ram_w_data, 32'h0);
        chk("rst_raddr",  bus.ram_r_addr, 32'h0);
        sys_rst_n = 1'b1;

        // store byte 0xA5 at 0x102
        send(1'b1, 2'd0, 1'b0, 32'h102, 32'h0000_00A5);
        mid_cycle();
        chk("sb_wen",    32'(bus.ram_wen), 32'b0100);
        chk("sb_waddr",  bus.ram_w_addr, 32'h100);
        chk("sb_lane2",  32'(bus.ram_w_data[23:16]), 32'hA5);
        chk("sb_rvalid", 32'(bus.rsp_valid), 32'd1);
        chk("sb_err",    32'(bus.rsp_err), 32'd0);
        chk("sb_ren",    32'(bus.ram_ren), 32'd0);
        chk("sb_ready1", 32'(bus.req_ready), 32'd0);
        mid_cycle();
        chk("sb_wen_t2",  32'(bus.ram_wen), 32'd0);
        chk("sb_rv_t2",   32'(bus.rsp_valid), 32'd0);
        chk("sb_ready_t2", 32'(bus.req_ready), 32'd1);

        // store word 0x80FF7F01 at 0x100
        send(1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF_7F01);
        mid_cycle();
        chk("sw_wen",   32'(bus.ram_wen), 32'hF);
        chk("sw_wdata", bus.ram_w_data, 32'h80FF_7F01);
        chk("sw_rvalid", 32'(bus.rsp_valid), 32'd1);

        // load half signed at 0x102
        send(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
        mid_cycle();
        chk("lhs_ren",    32'(bus.ram_ren), 32'd1);
        chk("lhs_raddr",  bus.ram_r_addr, 32'h100);
        chk("lhs_wen",    32'(bus.ram_wen), 32'd0);
        chk("lhs_rv_t1",  32'(bus.rsp_valid), 32'd0);
        mid_cycle();
        chk("lhs_rvalid", 32'(bus.rsp_valid), 32'd1);
        chk("lhs_rdata",  bus.rsp_rdata, 32'hFFFF_80FF);
        chk("lhs_err",    32'(bus.rsp_err), 32'd0);
        chk("lhs_ren_t2", 32'(bus.ram_ren), 32'd0);

        // load half unsigned at 0x102
        send(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
        mid_cycle();
        mid_cycle();
        chk("lhu_rdata", bus.rsp_rdata, 32'h0000_80FF);

        // load byte signed at 0x100, with ready timing
        send(1'b0, 2'd0, 1'b0, 32'h100, 32'h0);
        mid_cycle();
        chk("lb_ready_t1", 32'(bus.req_ready), 32'd0);
        mid_cycle();
        chk("lb_ready_t2", 32'(bus.req_ready), 32'd0);
        chk("lb_rdata",    bus.rsp_rdata, 32'h0000_0001);
        mid_cycle();
        chk("lb_ready_t3", 32'(bus.req_ready), 32'd1);
        chk("lb_rv_t3",    32'(bus.rsp_valid), 32'd0);

        // byte lanes 3 (signed) and 1 (unsigned)
        send(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        mid_cycle();
        mid_cycle();
        chk("lb3_rdata", bus.rsp_rdata, 32'hFFFF_FF80);
        send(1'b0, 2'd0, 1'b1, 32'h101, 32'h0);
        mid_cycle();
        mid_cycle();
        chk("lbu1_rdata", bus.rsp_rdata, 32'h0000_007F);

        // reserved size
        send(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
        mid_cycle();
        chk("rsv_rvalid", 32'(bus.rsp_valid), 32'd1);
        chk("rsv_err",    32'(bus.rsp_err), 32'd1);
        chk("rsv_rdata",  bus.rsp_rdata, 32'h0);
        chk("rsv_wen",    32'(bus.ram_wen), 32'd0);
        chk("rsv_ren",    32'(bus.ram_ren), 32'd0);
        mid_cycle();
        chk("rsv_ren_t2", 32'(bus.ram_ren), 32'd0);
        chk("rsv_rv_t2",  32'(bus.rsp_valid), 32'd0);

        // store half 0xBEEF at 0x102, then read the word back
        send(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_BEEF);
        mid_cycle();
        chk("sh_wen",   32'(bus.ram_wen), 32'b1100);
        chk("sh_hi",    32'(bus.ram_w_data[31:16]), 32'hBEEF);
        send(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        mid_cycle();
        mid_cycle();
        chk("lw_rdata", bus.rsp_rdata, 32'hBEEF_7F01);

`ifdef MISALIGN_SPLIT_EN
        send(1'b1, 2'd2, 1'b0, 32'h201, 32'h1122_3344);
        mid_cycle();
        chk("ms_wen1",   32'(bus.ram_wen), 32'b1110);
        chk("ms_waddr1", bus.ram_w_addr, 32'h200);
        chk("ms_wdata1", bus.ram_w_data, 32'h2233_4411);
        chk("ms_rv_t1",  32'(bus.rsp_valid), 32'd0);
        mid_cycle();
        chk("ms_wen2",   32'(bus.ram_wen), 32'b0001);
        chk("ms_waddr2", bus.ram_w_addr, 32'h204);
        chk("ms_rv_t2",  32'(bus.rsp_valid), 32'd1);
        chk("ms_err",    32'(bus.rsp_err), 32'd0);
        mid_cycle();
        chk("ms_ready_t3", 32'(bus.req_ready), 32'd1);

        send(1'b0, 2'd2, 1'b0, 32'h201, 32'h0);
        mid_cycle();
        chk("ml_ren1",   32'(bus.ram_ren), 32'd1);
        chk("ml_raddr1", bus.ram_r_addr, 32'h200);
        mid_cycle();
        chk("ml_ren2",   32'(bus.ram_ren), 32'd1);
        chk("ml_raddr2", bus.ram_r_addr, 32'h204);
        chk("ml_rv_t2",  32'(bus.rsp_valid), 32'd0);
        mid_cycle();
        chk("ml_rvalid", 32'(bus.rsp_valid), 32'd1);
        chk("ml_rdata",  bus.rsp_rdata, 32'h1122_3344);

        send(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'hCAFE_F00D);
        mid_cycle();
        chk("wrap_wen1",   32'(bus.ram_wen), 32'b1100);
        chk("wrap_waddr1", bus.ram_w_addr, 32'hFFFF_FFFC);
        mid_cycle();
        chk("wrap_wen2",   32'(bus.ram_wen), 32'b0011);
        chk("wrap_waddr2", bus.ram_w_addr, 32'h0);
`else
        send(1'b1, 2'd2, 1'b0, 32'h201, 32'h1122_3344);
        mid_cycle();
        chk("ms_rvalid", 32'(bus.rsp_valid), 32'd1);
        chk("ms_err",    32'(bus.rsp_err), 32'd1);
        chk("ms_wen",    32'(bus.ram_wen), 32'd0);
        mid_cycle();
        chk("ms_wen_t2", 32'(bus.ram_wen), 32'd0);

        send(1'b0, 2'd2, 1'b0, 32'h201, 32'h0);
        mid_cycle();
        chk("ml_rvalid", 32'(bus.rsp_valid), 32'd1);
        chk("ml_err",    32'(bus.rsp_err), 32'd1);
        chk("ml_rdata",  bus.rsp_rdata, 32'h0);
        chk("ml_ren",    32'(bus.ram_ren), 32'd0);
        mid_cycle();
        chk("ml_ren_t2", 32'(bus.ram_ren), 32'd0);
`endif

        // reset asserted at T+1 of a load
        send(1'b0, 2'd0, 1'b0, 32'h100, 32'h0);
        sys_rst_n = 1'b0;
        #1;
        chk("ar_ren",   32'(bus.ram_ren), 32'd0);
        chk("ar_wen",   32'(bus.ram_wen), 32'd0);
        chk("ar_rv",    32'(bus.rsp_valid), 32'd0);
        mid_cycle();
        chk("ar_rv_t2", 32'(bus.rsp_valid), 32'd0);
        chk("ar_ren_t2", 32'(bus.ram_ren), 32'd0);
        mid_cycle();
        chk("ar_rv_t3", 32'(bus.rsp_valid), 32'd0);
        sys_rst_n = 1'b1;

        // normal operation resumes after reset
        send(1'b0, 2'd1, 1'b1, 32'h100, 32'h0);
        mid_cycle();
        mid_cycle();
        chk("post_rst_rdata", bus.rsp_rdata, 32'h0000_7F01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
